// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffered, parametrised UART transmitter.
// Words arrive over a valid/ready handshake into a small circular FIFO.
// An FSM pops them and sends each one as a frame on rs232_tx.
// Bit timing is generated internally from BAUD_DIV.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (flushes FIFO, abandons frame)
//   tx_data     word to send (DATA_BITS wide)
//   tx_valid    producer offers tx_data
//   tx_ready    FIFO not full (combinational from the FIFO count)
//   rs232_tx    registered serial line, idle high
//   tx_busy     FSM is not in IDLE
//   fifo_count  number of words currently buffered
//
// state | meaning
// IDLE  | line high, waiting for a buffered word
// START | start bit (line low)
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit (only when PARITY != 0)
// STOP  | STOP_BITS stop bits (line high)
module uart_tx_frame #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               rs232_tx,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM
  state_t               state;
  state_t               state_nx;
  logic [BW-1:0]        baud_cnt;
  logic [BW-1:0]        baud_nx;
  logic [BW-1:0]        baud_adv;
  logic                 baud_wrap;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_nx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nx;
  logic                 par_bit;
  logic                 par_nx;
  logic                 par_head;
  logic                 tx_nx;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign baud_adv  = baud_wrap ? '0 : baud_cnt + 1'b1;
  // Parity is fixed when the word is popped; shifting later cannot disturb it.
  assign par_head  = (PARITY == 1) ? ~^head : ^head;
  assign tx_busy   = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    par_nx   = par_bit;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          par_nx   = par_head;
          baud_nx  = '0;
          state_nx = S_START;
        end
      end
      S_START: begin
        baud_nx = baud_adv;
        if (baud_wrap) begin
          bit_nx   = '0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        baud_nx = baud_adv;
        if (baud_wrap) begin
          if (bit_cnt == DATA_LAST) begin
            bit_nx   = '0;
            state_nx = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            shreg_nx = shreg >> 1;
          end
        end
      end
      S_PAR: begin
        baud_nx = baud_adv;
        if (baud_wrap) begin
          bit_nx   = '0;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        baud_nx = baud_adv;
        if (baud_wrap) begin
          if (bit_cnt == STOP_LAST) begin
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              pop      = 1'b1;
              shreg_nx = head;
              par_nx   = par_head;
              baud_nx  = '0;
              state_nx = S_START;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The line level is decoded from the next state so rs232_tx is a plain flop
  // that changes on the same edge as the state.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      S_IDLE:  tx_nx = 1'b1;
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shreg_nx[0];
      S_PAR:   tx_nx = par_nx;
      S_STOP:  tx_nx = 1'b1;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rs232_tx <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_nx;
      rs232_tx <= tx_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;

  logic       rdy0, tx0, busy0;
  logic       rdy1, tx1, busy1;
  logic       rdy2, tx2, busy2;
  logic [2:0] cnt0, cnt1, cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  int          st0[$];
  logic [15:0] last_rx[3];

  typedef struct {
    logic [7:0] data;
    logic       par_e7;  // even parity of data[6:0], hand computed
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1
  uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .rs232_tx(tx0), .tx_busy(busy0), .fifo_count(cnt0));
  // 7E2
  uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) d1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
    .tx_ready(rdy1), .rs232_tx(tx1), .tx_busy(busy1), .fifo_count(cnt1));
  // 7O2
  uart_tx_frame #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) d2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid),
    .tx_ready(rdy2), .rs232_tx(tx2), .tx_busy(busy2), .fifo_count(cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard input side: record every accepted word per instance.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (tx_valid && rdy0) q0.push_back(tx_data);
      if (tx_valid && rdy1) q1.push_back({1'b0, tx_data[6:0]});
      if (tx_valid && rdy2) q2.push_back({1'b0, tx_data[6:0]});
    end
  end

  function automatic logic line_of(input int id);
    case (id)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  // Line decoder: samples every cycle, checks each bit is held BD cycles,
  // then compares the whole frame against the model built from the queue head.
  task automatic monitor(input int id);
    int db, pm, sb, nb;
    db = (id == 0) ? 8 : 7;
    pm = (id == 0) ? 0 : ((id == 1) ? 2 : 1);
    sb = (id == 0) ? 1 : 2;
    nb = 1 + db + ((pm != 0) ? 1 : 0) + sb;
    forever begin
      @(negedge clk);
      if (rst_n && line_of(id) == 1'b0) begin
        logic [15:0] rx;
        logic [15:0] ex;
        logic [7:0]  d;
        logic        pb;
        logic        l;
        bit          abort;
        bit          unstable;
        bit          have;
        int          st;
        rx = '0;
        abort = 0;
        unstable = 0;
        st = cyc;
        for (int b = 0; b < nb && !abort; b++) begin
          for (int c = 0; c < BD; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) begin
              abort = 1;
              break;
            end
            l = line_of(id);
            if (c == 0) rx[b] = l;
            else if (l !== rx[b]) unstable = 1;
          end
        end
        if (!abort) begin
          have = 0;
          d = '0;
          case (id)
            0: if (q0.size() > 0) begin d = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin d = q2.pop_front(); have = 1; end
          endcase
          if (id == 0) st0.push_back(st);
          last_rx[id] = rx;
          chk($sformatf("bit_hold%0d", id), {31'd0, unstable}, 32'd0);
          if (!have) begin
            chk($sformatf("frame_unexpected%0d", id), 32'd1, 32'd0);
          end else begin
            ex = '0;
            pb = 1'b0;
            for (int i = 0; i < db; i++) begin
              ex[1+i] = d[i];
              pb = pb ^ d[i];
            end
            if (pm != 0) ex[1+db] = (pm == 1) ? ~pb : pb;
            for (int s = 0; s < sb; s++) ex[nb-1-s] = 1'b1;
            chk($sformatf("frame%0d", id), {16'd0, rx}, {16'd0, ex});
          end
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    tx_valid = v;
    tx_data  = d;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && !busy2 && cnt0 == 0 && cnt1 == 0 && cnt2 == 0) begin
        done = 1;
        break;
      end
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl0, bl1, bad, stall, cerr;
    logic [7:0] acc;
    bit got;

    tbl[0] = '{8'hA5, 1'b1};
    tbl[1] = '{8'h03, 1'b0};
    tbl[2] = '{8'h7F, 1'b1};
    tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'h5A, 1'b0};
    tbl[5] = '{8'h81, 1'b1};
    tbl[6] = '{8'h3C, 1'b0};
    tbl[7] = '{8'hFF, 1'b1};

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_during", {31'd0, tx0}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_count", {29'd0, cnt0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);

    // Single words: latency, frame length, parity bit
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].data);
      drive(1'b0, 8'h00);
      chk("lat_count1", {29'd0, cnt0}, 32'd1);
      chk("lat_tx_idle", {31'd0, tx0}, 32'd1);
      chk("lat_busy0", {31'd0, busy0}, 32'd0);
      drive(1'b0, 8'h00);
      chk("lat_busy1", {31'd0, busy0}, 32'd1);
      chk("lat_start", {31'd0, tx0}, 32'd0);
      chk("lat_count0", {29'd0, cnt0}, 32'd0);
      bl0 = 0;
      bl1 = 0;
      for (int k = 0; k < 120; k++) begin
        if (busy0) bl0++;
        if (busy1) bl1++;
        if (!busy0 && !busy1 && !busy2) break;
        @(negedge clk);
      end
      chk("frame_len_8n1", bl0, 40);
      chk("frame_len_7e2", bl1, 44);
      chk("par_even", {31'd0, last_rx[1][8]}, {31'd0, tbl[i].par_e7});
      chk("par_odd", {31'd0, last_rx[2][8]}, {31'd0, ~tbl[i].par_e7});
    end

    // FIFO fill: 6 cycles of valid, 5 words taken, back-to-back frames
    st0.delete();
    for (int k = 0; k < 6; k++) drive(1'b1, 8'h10 + 8'(k));
    drive(1'b0, 8'h00);
    chk("fill_count", {29'd0, cnt0}, 32'd4);
    chk("fill_ready", {31'd0, rdy0}, 32'd0);
    wait_idle(400);
    chk("fill_frames", st0.size(), 5);
    for (int k = 1; k < 5 && k < st0.size(); k++)
      chk("fill_gap", st0[k] - st0[k-1], 40);

    // Push coincident with end-of-stop pop at count 2
    drive(1'b1, 8'hC1);
    drive(1'b1, 8'hC2);
    drive(1'b1, 8'hC3);
    for (int k = 0; k < 38; k++) drive(1'b0, 8'h00);
    drive(1'b1, 8'hC4);
    chk("pp_count_before", {29'd0, cnt0}, 32'd2);
    drive(1'b0, 8'h00);
    chk("pp_count_after", {29'd0, cnt0}, 32'd2);
    chk("pp_next_start", {31'd0, tx0}, 32'd0);
    wait_idle(400);

    // Reset during data bit 3
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    for (int k = 0; k < 16; k++) drive(1'b0, 8'h00);
    chk("mid_tx_low", {31'd0, tx0}, 32'd0);
    chk("mid_busy", {31'd0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {31'd0, tx0}, 32'd1);
    chk("arst_count", {29'd0, cnt0}, 32'd0);
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_ready", {31'd0, rdy0}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || tx2 !== 1'b1) bad++;
    end
    chk("post_rst_idle", bad, 0);

    // Stall: valid held while full, data changing every cycle
    for (int k = 0; k < 6; k++) drive(1'b1, 8'h20 + 8'(k));
    stall = 0;
    cerr = 0;
    got = 0;
    acc = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h40 + 8'(k);
      if (rdy0) begin
        acc = tx_data;
        got = 1;
        break;
      end
      stall++;
      if (cnt0 != 3'd4) cerr++;
    end
    drive(1'b0, 8'h00);
    chk("stall_accepted", {31'd0, got}, 32'd1);
    chk("stall_len_ge20", {31'd0, (stall >= 20)}, 32'd1);
    chk("stall_count_held", cerr, 0);
    wait_idle(600);
    chk("stall_word", {24'd0, last_rx[0][8:1]}, {24'd0, acc});

    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);
    chk("sb_empty2", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
